line_buffer_ctrl: RTL and testbench

Sequencer for the three row-buffer BRAMs feeding the 3x3 kernel datapath in the pcam-5c video pipeline.
- Tracks pixel column and row from the vid_io sync/VDE stream.
- Generates a shared write/read address and a rotating one-hot write enable.
- Reports which buffer holds row y-2 (top) and row y-1 (middle), and when a full 3x3 window is available.

---
 rtl/lbc_pkg.sv | 29 ++
 rtl/line_buffer_ctrl_if.sv | 45 ++++
 rtl/lbc_edge_det.sv | 23 ++
 rtl/line_buffer_ctrl.sv | 154 +++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lbc_pkg.sv
// Shared types and helpers for the line-buffer controller.
// Holds the buffer count, the FSM encoding and the mod-3 buffer-index helpers.
package lbc_pkg;

    localparam int NUM_BUFS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } lbc_state_e;

    function automatic logic [NUM_BUFS-1:0] onehot3(input logic [1:0] idx);
        logic [NUM_BUFS-1:0] oh;
        oh = '0;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] next_sel(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Video-in / buffer-control bundle for line_buffer_ctrl.
// o_border exists only when LBC_BORDER_EN is defined.
interface line_buffer_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int ROW_WIDTH  = 11
);
    import lbc_pkg::*;

    logic                  i_vid_hsync;
    logic                  i_vid_vsync;
    logic                  i_vid_VDE;
    logic [NUM_BUFS-1:0]   o_wr_en;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [1:0]            o_sel_top;
    logic [1:0]            o_sel_mid;
    logic [ADDR_WIDTH-1:0] o_col;
    logic [ROW_WIDTH-1:0]  o_row;
    logic                  o_window_valid;
    logic                  o_line_err;
    lbc_state_e            o_dbg_state;
`ifdef LBC_BORDER_EN
    logic                  o_border;
`endif

    // Video timing has no back-pressure: the source drives i_vid_* every cycle
    // and the controller consumes them unconditionally; no valid/ready pair.
    modport slave (
        input  i_vid_hsync, i_vid_vsync, i_vid_VDE,
        output o_wr_en, o_addr, o_sel_top, o_sel_mid, o_col, o_row,
               o_window_valid, o_line_err, o_dbg_state
`ifdef LBC_BORDER_EN
        , output o_border
`endif
    );

    modport master (
        output i_vid_hsync, i_vid_vsync, i_vid_VDE,
        input  o_wr_en, o_addr, o_sel_top, o_sel_mid, o_col, o_row,
               o_window_valid, o_line_err, o_dbg_state
`ifdef LBC_BORDER_EN
        , input o_border
`endif
    );

endinterface

// File: rtl/lbc_edge_det.sv
// Single-edge detector: compares the live input with a one-cycle registered copy.
// DET_RISE selects rising (1) or falling (0) edge.
module lbc_edge_det #(
    parameter logic DET_RISE = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_d,
    output logic o_edge
);

    logic d_q, d_d;

    assign d_d = i_d;

    always_ff @(posedge clk) begin
        if (!n_rst) d_q <= 1'b0;
        else        d_q <= d_d;
    end

    assign o_edge = DET_RISE ? (i_d & ~d_q) : (~i_d & d_q);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Row-buffer sequencer for the 3x3 kernel: rotating write enable, shared address,
// top/mid buffer selects and window-valid. Optional o_border under LBC_BORDER_EN.
module line_buffer_ctrl
    import lbc_pkg::*;
#(
    parameter int LINE_WIDTH = 1920,
    parameter int ADDR_WIDTH = 11,
    parameter int ROW_WIDTH  = 11
) (
    input  logic               clk,
    input  logic               n_rst,
    line_buffer_ctrl_if.slave  bus
);

    // One extra bit so col can sit at LINE_WIDTH even when it equals 2^ADDR_WIDTH.
    localparam int                   COL_W    = ADDR_WIDTH + 1;
    localparam logic [COL_W-1:0]     LINE_LEN = COL_W'(LINE_WIDTH);
    localparam logic [ROW_WIDTH-1:0] ROW_MAX  = '1;

    logic vs_rise, vde_fall;

    lbc_edge_det #(.DET_RISE(1'b1)) u_vsync_edge (
        .clk(clk), .n_rst(n_rst), .i_d(bus.i_vid_vsync), .o_edge(vs_rise)
    );

    lbc_edge_det #(.DET_RISE(1'b0)) u_vde_edge (
        .clk(clk), .n_rst(n_rst), .i_d(bus.i_vid_VDE), .o_edge(vde_fall)
    );

    lbc_state_e            state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_WIDTH-1:0]  row_q, row_d;
    logic [1:0]            wr_sel_q, wr_sel_d;
    logic [NUM_BUFS-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            sel_top_q, sel_top_d;
    logic [1:0]            sel_mid_q, sel_mid_d;
    logic                  window_valid_q, window_valid_d;
    logic                  line_err_q, line_err_d;
    logic                  ovf_q, ovf_d;
    logic                  border_q, border_d;
    logic                  line_wr;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            wr_sel_q       <= 2'd0;
            wr_en_q        <= '0;
            addr_q         <= '0;
            sel_top_q      <= 2'd1;
            sel_mid_q      <= 2'd2;
            window_valid_q <= 1'b0;
            line_err_q     <= 1'b0;
            ovf_q          <= 1'b0;
            border_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            wr_sel_q       <= wr_sel_d;
            wr_en_q        <= wr_en_d;
            addr_q         <= addr_d;
            sel_top_q      <= sel_top_d;
            sel_mid_q      <= sel_mid_d;
            window_valid_q <= window_valid_d;
            line_err_q     <= line_err_d;
            ovf_q          <= ovf_d;
            border_q       <= border_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        wr_sel_d       = wr_sel_q;
        wr_en_d        = '0;
        addr_d         = addr_q;
        window_valid_d = 1'b0;
        line_err_d     = 1'b0;
        ovf_d          = ovf_q;
        border_d       = 1'b0;
        line_wr        = 1'b0;

        // Frame start outranks everything, including a coincident line end.
        if (vs_rise) begin
            state_d  = BLANK;
            col_d    = '0;
            row_d    = '0;
            wr_sel_d = 2'd0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                BLANK: begin
                    if (bus.i_vid_VDE) begin
                        state_d = ACTIVE;
                        line_wr = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vde_fall) begin
                        state_d    = BLANK;
                        wr_sel_d   = next_sel(wr_sel_q);
                        row_d      = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;
                        col_d      = '0;
                        line_err_d = (col_q != LINE_LEN) || ovf_q;
                        ovf_d      = 1'b0;
                    end else if (bus.i_vid_VDE) begin
                        line_wr = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (line_wr) begin
            if (col_q < LINE_LEN) begin
                wr_en_d        = onehot3(wr_sel_q);
                addr_d         = col_q[ADDR_WIDTH-1:0];
                window_valid_d = (row_q >= ROW_WIDTH'(2)) && (col_q >= COL_W'(2));
                border_d       = (col_q == '0) || (col_q == LINE_LEN - 1'b1) ||
                                 (row_q < ROW_WIDTH'(2));
                col_d          = col_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // The buffer just written becomes mid; the oldest becomes top.
        sel_top_d = next_sel(wr_sel_d);
        sel_mid_d = next_sel(next_sel(wr_sel_d));
    end

    assign bus.o_wr_en        = wr_en_q;
    assign bus.o_addr         = addr_q;
    assign bus.o_sel_top      = sel_top_q;
    assign bus.o_sel_mid      = sel_mid_q;
    assign bus.o_col          = col_q[ADDR_WIDTH-1:0];
    assign bus.o_row          = row_q;
    assign bus.o_window_valid = window_valid_q;
    assign bus.o_line_err     = line_err_q;
    assign bus.o_dbg_state    = state_q;

`ifdef LBC_BORDER_EN
    assign bus.o_border = border_q;
`else
    logic border_unused;
    assign border_unused = border_q;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with LINE_WIDTH=8.
// o_border is checked only when LBC_BORDER_EN is defined.
module tb_line_buffer_ctrl;
    import lbc_pkg::*;

    localparam int LW = 8;
    localparam int AW = 4;
    localparam int RW = 11;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   wv_count = 0;

    always #5 clk = ~clk;

    line_buffer_ctrl_if #(.ADDR_WIDTH(AW), .ROW_WIDTH(RW)) vif ();

    line_buffer_ctrl #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (vif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line of n VDE cycles written to buffer idx at row; top/mid are the selects
    // during the line. Afterwards the written buffer becomes mid and old mid becomes top.
    task automatic send_line(input int n, input int idx, input int row,
                             input int top, input int mid);
        for (int i = 0; i < n; i++) begin
            vif.i_vid_VDE = 1'b1;
            tick();
            if (i < LW) begin
                chk("wr_en", vif.o_wr_en, 32'(1) << idx);
                chk("addr", vif.o_addr, i);
                chk("col", vif.o_col, i + 1);
                chk("window", vif.o_window_valid, (row >= 2 && i >= 2));
            end else begin
                chk("wr_en_ovl", vif.o_wr_en, 0);
                chk("col_hold", vif.o_col, LW);
                chk("window_ovl", vif.o_window_valid, 0);
            end
`ifdef LBC_BORDER_EN
            chk("border", vif.o_border, (i < LW) && (i == 0 || i == LW - 1 || row < 2));
`endif
            if (vif.o_window_valid) wv_count++;
            chk("row", vif.o_row, row);
            chk("sel_top", vif.o_sel_top, top);
            chk("sel_mid", vif.o_sel_mid, mid);
            chk("err_mid", vif.o_line_err, 0);
        end
        vif.i_vid_VDE = 1'b0;
        tick();
        chk("line_err", vif.o_line_err, (n != LW));
        chk("col_clr", vif.o_col, 0);
        chk("row_inc", vif.o_row, row + 1);
        chk("wr_en_off", vif.o_wr_en, 0);
        chk("sel_top_rot", vif.o_sel_top, mid);
        chk("sel_mid_rot", vif.o_sel_mid, idx);
        tick();
        chk("err_pulse", vif.o_line_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vif.i_vid_hsync = 1'b0;
        vif.i_vid_vsync = 1'b0;
        vif.i_vid_VDE   = 1'b0;

        // 1: reset, then VDE without vsync stays idle
        n_rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_wr_en", vif.o_wr_en, 0);
        chk("rst_addr", vif.o_addr, 0);
        chk("rst_col", vif.o_col, 0);
        chk("rst_row", vif.o_row, 0);
        chk("rst_win", vif.o_window_valid, 0);
        chk("rst_err", vif.o_line_err, 0);
        chk("rst_top", vif.o_sel_top, 1);
        chk("rst_mid", vif.o_sel_mid, 2);
        chk("rst_state", vif.o_dbg_state, IDLE);
        n_rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            vif.i_vid_VDE = 1'b1;
            vif.i_vid_hsync = i[0];
            tick();
            chk("idle_wr_en", vif.o_wr_en, 0);
            chk("idle_row", vif.o_row, 0);
            chk("idle_state", vif.o_dbg_state, IDLE);
        end
        vif.i_vid_VDE = 1'b0;
        vif.i_vid_hsync = 1'b0;
        tick();
        chk("idle_err", vif.o_line_err, 0);

        // 2: frame start, three full lines
        vif.i_vid_vsync = 1'b1;
        tick();
        chk("fs_state", vif.o_dbg_state, BLANK);
        vif.i_vid_vsync = 1'b0;
        tick();
        wv_count = 0;
        send_line(8, 0, 0, 1, 2);
        send_line(8, 1, 1, 2, 0);
        send_line(8, 2, 2, 0, 1);
        chk("win_count", wv_count, 6);

        // 3: short line then overlong line
        send_line(6, 0, 3, 1, 2);
        send_line(10, 1, 4, 2, 0);

        // 4: vsync at col 4 of row 5
        for (int i = 0; i < 4; i++) begin
            vif.i_vid_VDE = 1'b1;
            tick();
            chk("r5_wr_en", vif.o_wr_en, 3'b100);
            chk("r5_addr", vif.o_addr, i);
        end
        vif.i_vid_vsync = 1'b1;
        tick();
        chk("abort_row", vif.o_row, 0);
        chk("abort_col", vif.o_col, 0);
        chk("abort_wr_en", vif.o_wr_en, 0);
        chk("abort_err", vif.o_line_err, 0);
        chk("abort_top", vif.o_sel_top, 1);
        chk("abort_mid", vif.o_sel_mid, 2);
        chk("abort_state", vif.o_dbg_state, BLANK);
        vif.i_vid_VDE = 1'b0;
        tick();
        chk("abort_err2", vif.o_line_err, 0);
        chk("abort_row2", vif.o_row, 0);
        vif.i_vid_vsync = 1'b0;
        tick();

        // vsync rise coinciding with VDE fall
        for (int i = 0; i < 3; i++) begin
            vif.i_vid_VDE = 1'b1;
            tick();
            chk("co_wr_en", vif.o_wr_en, 3'b001);
        end
        vif.i_vid_VDE   = 1'b0;
        vif.i_vid_vsync = 1'b1;
        tick();
        chk("co_err", vif.o_line_err, 0);
        chk("co_row", vif.o_row, 0);
        chk("co_col", vif.o_col, 0);
        chk("co_top", vif.o_sel_top, 1);
        chk("co_mid", vif.o_sel_mid, 2);
        vif.i_vid_vsync = 1'b0;
        tick();

        // 5: reset mid-line at row 3
        send_line(8, 0, 0, 1, 2);
        send_line(8, 1, 1, 2, 0);
        send_line(8, 2, 2, 0, 1);
        for (int i = 0; i < 3; i++) begin
            vif.i_vid_VDE = 1'b1;
            tick();
            chk("r3_wr_en", vif.o_wr_en, 3'b001);
            chk("r3_win", vif.o_window_valid, (i >= 2));
        end
        n_rst = 1'b0;
        tick();
        chk("mrst_wr_en", vif.o_wr_en, 0);
        chk("mrst_addr", vif.o_addr, 0);
        chk("mrst_col", vif.o_col, 0);
        chk("mrst_row", vif.o_row, 0);
        chk("mrst_win", vif.o_window_valid, 0);
        chk("mrst_top", vif.o_sel_top, 1);
        chk("mrst_mid", vif.o_sel_mid, 2);
        chk("mrst_state", vif.o_dbg_state, IDLE);
        n_rst = 1'b1;
        tick();
        chk("post_rst_wr_en", vif.o_wr_en, 0);
        tick();
        chk("post_rst_state", vif.o_dbg_state, IDLE);
        vif.i_vid_VDE = 1'b0;
        tick();
        chk("post_rst_err", vif.o_line_err, 0);
        vif.i_vid_vsync = 1'b1;
        tick();
        vif.i_vid_vsync = 1'b0;
        tick();

        // 6: clean 4-line frame (border checked in LBC_BORDER_EN builds)
        send_line(8, 0, 0, 1, 2);
        send_line(8, 1, 1, 2, 0);
        send_line(8, 2, 2, 0, 1);
        send_line(8, 0, 3, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
